// File: rtl/tcdm_responder.sv
// Single-bank TCDM responder: round-robin arbitration over NB_PORTS request ports, one access per cycle, read data one cycle after grant.
// Optional pseudo-random grant stalls are compiled in with `define TCDM_RESPONDER_STALL_EN.
module tcdm_responder #(
  parameter int unsigned NB_PORTS   = 3,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [NB_PORTS-1:0] tcdm_req,
  output logic [NB_PORTS-1:0] tcdm_gnt,
  input  logic [31:0]         tcdm_add    [NB_PORTS],
  input  logic [NB_PORTS-1:0] tcdm_wen,
  input  logic [3:0]          tcdm_be     [NB_PORTS],
  input  logic [31:0]         tcdm_data   [NB_PORTS],
  output logic [31:0]         tcdm_r_data [NB_PORTS],
  output logic [NB_PORTS-1:0] tcdm_r_valid,
  output logic [31:0]         conflict_cnt_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [31:0]   mem [MEM_WORDS];
  logic [PW-1:0] rr_q;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] nxt_ptr;
  logic          win_found;
  logic          grant_en;
  logic          stall;
  logic          conflict_now;
  logic [AW-1:0] win_word;
  int unsigned   arb_cand;
  logic          unused_add_bits;

  // ---------------------------------------------------------------------------
  // Stall source
  // ---------------------------------------------------------------------------
`ifdef TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; restarts from the seed on reset and clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_q wins
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    arb_cand  = 0;
    for (int unsigned i = 0; i < NB_PORTS; i++) begin
      arb_cand = {{(32-PW){1'b0}}, rr_q} + i;
      if (arb_cand >= NB_PORTS) arb_cand = arb_cand - NB_PORTS;
      if (!win_found && tcdm_req[arb_cand]) begin
        win_found = 1'b1;
        win_idx   = arb_cand[PW-1:0];
      end
    end
  end

  // Grants are withheld while reset/clear is asserted so nothing transfers into a state being wiped.
  assign grant_en     = win_found && !stall && !rst_i && !clear_i;
  assign nxt_ptr      = (win_idx == PW'(NB_PORTS - 1)) ? '0 : win_idx + 1'b1;
  assign win_word     = tcdm_add[win_idx][2 +: AW];
  assign conflict_now = ($countones(tcdm_req) > 1) && !stall;

  always_comb begin
    tcdm_gnt = '0;
    if (grant_en) tcdm_gnt[win_idx] = 1'b1;
  end

  // Only the word-index field of the address selects storage.
  always_comb begin
    unused_add_bits = 1'b0;
    for (int unsigned k = 0; k < NB_PORTS; k++) begin
      unused_add_bits = unused_add_bits ^ (^{tcdm_add[k][31:AW+2], tcdm_add[k][1:0]});
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: byte-enabled write at the grant edge
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; clearing a RAM costs a write port per word and its contents are undefined after reset anyway.
  always_ff @(posedge clk_i) begin
    if (grant_en && !tcdm_wen[win_idx]) begin
      for (int unsigned j = 0; j < 4; j++) begin
        if (tcdm_be[win_idx][j]) mem[win_word][8*j +: 8] <= tcdm_data[win_idx][8*j +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state, read response and conflict counter
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, matching the hardware.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_q           <= '0;
      tcdm_r_valid   <= '0;
      tcdm_r_data    <= '{default: '0};
      conflict_cnt_o <= '0;
    end else begin
      tcdm_r_valid <= '0;
      if (grant_en) begin
        rr_q <= nxt_ptr;
        if (tcdm_wen[win_idx]) begin
          tcdm_r_valid[win_idx] <= 1'b1;
          tcdm_r_data[win_idx]  <= mem[win_word];
        end
      end
      if (conflict_now && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk_i) $onehot0(tcdm_gnt));
  a_gnt_has_req : assert property (@(posedge clk_i) (tcdm_gnt & ~tcdm_req) == '0);
  a_seed_nonzero: assert property (@(posedge clk_i) STALL_SEED != 16'h0);

endmodule

// File: tb/tb_tcdm_responder.sv
// Directed bench for tcdm_responder: drivers push expected read data into per-port queues, a monitor pops on r_valid.
module tb_tcdm_responder;

  localparam int NP = 3;
  localparam int MW = 1024;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [31:0] add    [NP];
  logic [2:0]  wen;
  logic [3:0]  be     [NP];
  logic [31:0] data   [NP];
  logic [31:0] r_data [NP];
  logic [2:0]  r_valid;
  logic [31:0] conflict;

  exp_t        sb [NP][$];
  logic [31:0] model [MW];
  int          cyc;
  int          n_cmp;
  int          n_err;

  tcdm_responder #(.NB_PORTS(NP), .MEM_WORDS(MW), .STALL_SEED(16'hACE1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .tcdm_req      (req),
    .tcdm_gnt      (gnt),
    .tcdm_add      (add),
    .tcdm_wen      (wen),
    .tcdm_be       (be),
    .tcdm_data     (data),
    .tcdm_r_data   (r_data),
    .tcdm_r_valid  (r_valid),
    .conflict_cnt_o(conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every r_valid must match the oldest expectation for that port, one cycle after its grant.
  always @(negedge clk) begin
    for (int k = 0; k < NP; k++) begin
      if (r_valid[k]) begin
        if (sb[k].size() == 0) begin
          check($sformatf("p%0d_spurious_r_valid", k), {31'b0, r_valid[k]}, 32'd0);
        end else begin
          exp_t e;
          e = sb[k].pop_front();
          check($sformatf("p%0d_r_data", k), r_data[k], e.data);
          check($sformatf("p%0d_r_valid_cycle", k), 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // One request on port p, held until granted. Reads expect exp_hand when hand=1, else the reference model.
  task automatic access(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic hand, input logic [31:0] exp_hand,
                        output int lat);
    exp_t e;
    tick();
    req[p]  = 1'b1;
    add[p]  = a;
    wen[p]  = w;
    be[p]   = b;
    data[p] = d;
    lat     = 0;
    @(negedge clk);
    while (!gnt[p] && lat < 64) begin
      lat++;
      @(negedge clk);
    end
    if (!gnt[p]) begin
      check($sformatf("p%0d_gnt_timeout", p), {31'b0, gnt[p]}, 32'd1);
    end else if (!w) begin
      for (int j = 0; j < 4; j++) begin
        if (b[j]) model[a[11:2]][8*j +: 8] = d[8*j +: 8];
      end
    end else begin
      e.data = hand ? exp_hand : model[a[11:2]];
      e.cyc  = cyc + 1;
      sb[p].push_back(e);
    end
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n_ops);
    int          lat;
    logic [31:0] a;
    for (int n = 0; n < n_ops; n++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      access(p, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b0, 32'h0, lat);
    end
  endtask

  initial begin
    int   lat;
    int   lat2;
    exp_t e;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear = 1'b0;
    req   = 3'b111;
    wen   = 3'b111;
    for (int k = 0; k < NP; k++) begin
      add[k]  = 32'h0;
      be[k]   = 4'h0;
      data[k] = 32'h0;
    end

    // Reset state, with every port requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", {29'b0, gnt}, 32'd0);
    check("reset_r_valid", {29'b0, r_valid}, 32'd0);
    check("reset_conflict", conflict, 32'd0);
    for (int k = 0; k < NP; k++) check($sformatf("reset_r_data%0d", k), r_data[k], 32'd0);
    tick();
    rst = 1'b0;
    req = 3'b000;

    // Full write then read back; grant in the same cycle as the request.
    access(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, lat);
`ifndef TCDM_RESPONDER_STALL_EN
    check("write_gnt_latency", 32'(lat), 32'd0);
`endif
    access(0, 32'h10, 1'b1, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, lat);

    // Partial write: bytes 0 and 2 replaced.
    access(0, 32'h10, 1'b0, 4'b0101, 32'h11223344, 1'b1, 32'h0, lat);
    access(0, 32'h10, 1'b1, 4'h0, 32'h0, 1'b1, 32'hDE22BE44, lat);

    // Address wrap and ignored low bits.
    access(0, 32'h0000_1010, 1'b1, 4'h0, 32'h0, 1'b1, 32'hDE22BE44, lat);
    access(0, 32'h8000_1013, 1'b1, 4'h0, 32'h0, 1'b1, 32'hDE22BE44, lat);

    // Write on port 1 and read on port 2 of the same word, granted back to back (pointer is at 1).
    fork
      access(1, 32'h20, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, lat);
      access(2, 32'h20, 1'b1, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D, lat2);
    join
`ifndef TCDM_RESPONDER_STALL_EN
    check("raw_first_latency", 32'(lat), 32'd0);
    check("raw_second_latency", 32'(lat2), 32'd1);
`endif

    // Preload three words, clear, then all ports read continuously.
    access(0, 32'h100, 1'b0, 4'hF, 32'hA0A0_0000, 1'b1, 32'h0, lat);
    access(0, 32'h104, 1'b0, 4'hF, 32'hA1A1_1111, 1'b1, 32'h0, lat);
    access(0, 32'h108, 1'b0, 4'hF, 32'hA2A2_2222, 1'b1, 32'h0, lat);
`ifndef TCDM_RESPONDER_STALL_EN
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < NP; k++) begin
      add[k] = 32'h100 + 32'(4 * k);
      wen[k] = 1'b1;
    end
    req = 3'b111;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      check($sformatf("rr_gnt_%0d", j), {29'b0, gnt}, 32'd1 << (j % 3));
      check($sformatf("conflict_cnt_%0d", j), conflict, 32'(j));
      case (j % 3)
        0:       e.data = 32'hA0A0_0000;
        1:       e.data = 32'hA1A1_1111;
        default: e.data = 32'hA2A2_2222;
      endcase
      e.cyc = cyc + 1;
      sb[j % 3].push_back(e);
    end
    tick();
    req = 3'b000;
    @(negedge clk);
    check("conflict_cnt_final", conflict, 32'd9);
`endif

    // Reset raised in a cycle where a read is being granted: no response, counter back to zero.
    tick();
    req[0] = 1'b1;
    add[0] = 32'h10;
    wen[0] = 1'b1;
    lat    = 0;
    @(negedge clk);
    while (!gnt[0] && lat < 64) begin
      lat++;
      @(negedge clk);
    end
    check("rst_pre_gnt", {31'b0, gnt[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_gnt_forced", {29'b0, gnt}, 32'd0);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    check("rst_r_valid", {29'b0, r_valid}, 32'd0);
    check("rst_conflict", conflict, 32'd0);
    check("rst_r_data0", r_data[0], 32'd0);
    tick();
    rst = 1'b0;

    // Memory is undefined after reset: rewrite the random working set, then mixed traffic on all ports.
    for (int w = 0; w < 16; w++) begin
      access(0, 32'(w) << 2, 1'b0, 4'hF, 32'h5A00_0000 | 32'(w), 1'b1, 32'h0, lat);
    end
    fork
      rand_port(0, 30);
      rand_port(1, 30);
      rand_port(2, 30);
    join

    repeat (3) tick();
    for (int k = 0; k < NP; k++) check($sformatf("p%0d_pending_at_end", k), 32'(sb[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
